// File: rtl/comm_host.sv
// Host initiator for the console-mux UART command protocol: send cmd + payload, collect reply (ECHO_CHECK_EN: verify write echo).
// BADCMD answers one cycle after accept; new requests are held off (req_ready=0) until the current one completes.
module comm_host #(
  parameter int OUTPUT_COUNT   = 16,
  parameter int INPUT_COUNT    = 4,
  parameter int TIMEOUT_CYCLES = 4096,
  localparam int SEL_WIDTH     = $clog2(INPUT_COUNT) * OUTPUT_COUNT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [2:0]              req_cmd,
  input  logic [OUTPUT_COUNT-1:0] wr_enable_mask,
  input  logic [SEL_WIDTH-1:0]    wr_pin_map,
  output logic [OUTPUT_COUNT-1:0] rd_enable_mask,
  output logic [SEL_WIDTH-1:0]    rd_pin_map,
  output logic                    resp_valid,
  output logic [1:0]              resp_err,
  output logic                    busy,
  output logic [7:0]              tx_byte,
  output logic                    tx_start,
  input  logic                    tx_done,
  input  logic [7:0]              rx_byte,
  input  logic                    rx_ready
);

  localparam int DW = (SEL_WIDTH > OUTPUT_COUNT) ? SEL_WIDTH : OUTPUT_COUNT;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [3:0] MB4 = 4'(OUTPUT_COUNT / 8);
  localparam logic [3:0] PB4 = 4'(SEL_WIDTH / 8);
  localparam logic [2:0] C_RD_MASK = 3'd1, C_RD_MAP = 3'd2, C_WR_MASK = 3'd3, C_WR_MAP = 3'd4;
  localparam logic [1:0] E_OK = 2'd0, E_TMO = 2'd1, E_BAD = 2'd2, E_MIS = 2'd3;

  typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT_BUSY, S_WAIT_IDLE, S_RECV, S_DONE} state_t;

  state_t          state, state_d;
  logic [1:0]      err_q, err_d;
  logic [2:0]      cmd_q;
  logic [DW-1:0]   payload_q, shadow;
  logic [DW+7:0]   frame;
  logic [3:0]      tx_cnt, tx_total, rx_cnt, rx_total;
  logic [TW-1:0]   tmo_cnt;
  logic            armed, rx_ready_d;
  logic            accept, issue_tx, cmd_ok, rx_hit, rx_take, timed, tmo_exp, rx_full, echo_bad;

  // Byte 0 on the wire is the command, payload bytes follow LSB first.
  assign frame     = {payload_q, 5'b0, cmd_q};
  assign req_ready = (state == S_IDLE);
  assign busy      = ~req_ready;
  assign resp_valid = (state == S_DONE);
  assign resp_err  = err_q;

  assign cmd_ok  = (req_cmd >= C_RD_MASK) && (req_cmd <= C_WR_MAP);
  assign rx_hit  = armed & rx_ready & ~rx_ready_d;
  assign rx_take = rx_hit & (rx_cnt < rx_total);
  assign rx_full = (rx_cnt == rx_total);
  assign timed   = (state == S_WAIT_BUSY) || (state == S_WAIT_IDLE) || (state == S_RECV);
  // A byte landing on the expiry cycle wins over the timeout.
  assign tmo_exp = timed & ~rx_hit & (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

`ifdef ECHO_CHECK_EN
  assign echo_bad = ((cmd_q == C_WR_MASK) && (shadow[OUTPUT_COUNT-1:0] != payload_q[OUTPUT_COUNT-1:0])) ||
                    ((cmd_q == C_WR_MAP)  && (shadow[SEL_WIDTH-1:0]    != payload_q[SEL_WIDTH-1:0]));
`else
  assign echo_bad = 1'b0;
`endif

  always_comb begin
    state_d  = state;
    err_d    = err_q;
    accept   = 1'b0;
    issue_tx = 1'b0;
    case (state)
      S_IDLE: if (req_valid) begin
        accept = 1'b1;
        if (cmd_ok) state_d = S_SEND;
        else begin
          state_d = S_DONE;
          err_d   = E_BAD;
        end
      end
      S_SEND: if (tx_done) begin
        issue_tx = 1'b1;
        state_d  = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: if (tmo_exp) begin
        state_d = S_DONE;
        err_d   = E_TMO;
      end else if (!tx_done) state_d = S_WAIT_IDLE;
      S_WAIT_IDLE: if (tmo_exp) begin
        state_d = S_DONE;
        err_d   = E_TMO;
      end else if (tx_done) state_d = (tx_cnt == tx_total) ? S_RECV : S_SEND;
      S_RECV: if (rx_full) begin
        state_d = S_DONE;
        err_d   = echo_bad ? E_MIS : E_OK;
      end else if (tmo_exp) begin
        state_d = S_DONE;
        err_d   = E_TMO;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      err_q <= E_OK;
    end else begin
      state <= state_d;
      err_q <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q          <= '0;
      payload_q      <= '0;
      shadow         <= '0;
      tx_cnt         <= '0;
      tx_total       <= '0;
      rx_cnt         <= '0;
      rx_total       <= '0;
      tmo_cnt        <= '0;
      armed          <= 1'b0;
      rx_ready_d     <= 1'b0;
      tx_start       <= 1'b0;
      tx_byte        <= 8'hFF;
      rd_enable_mask <= '0;
      rd_pin_map     <= '0;
    end else begin
      tx_start   <= issue_tx;
      rx_ready_d <= rx_ready;
      if (accept) begin
        cmd_q     <= req_cmd;
        payload_q <= (req_cmd == C_WR_MASK) ? DW'(wr_enable_mask) : DW'(wr_pin_map);
        tx_cnt    <= '0;
        rx_cnt    <= '0;
        armed     <= 1'b0;
        case (req_cmd)
          C_RD_MASK: begin tx_total <= 4'd1;      rx_total <= MB4; end
          C_RD_MAP:  begin tx_total <= 4'd1;      rx_total <= PB4; end
          C_WR_MASK: begin tx_total <= MB4 + 4'd1; rx_total <= MB4; end
          C_WR_MAP:  begin tx_total <= PB4 + 4'd1; rx_total <= PB4; end
          default:   begin tx_total <= 4'd0;      rx_total <= 4'd0; end
        endcase
      end
      if (issue_tx) begin
        tx_byte <= frame[{tx_cnt, 3'b000} +: 8];
        tx_cnt  <= tx_cnt + 4'd1;
        if (tx_cnt + 4'd1 == tx_total) armed <= 1'b1;
      end
      if (rx_take) begin
        shadow[{rx_cnt, 3'b000} +: 8] <= rx_byte;
        rx_cnt <= rx_cnt + 4'd1;
      end
      if (issue_tx || rx_hit) tmo_cnt <= '0;
      else if (timed)         tmo_cnt <= tmo_cnt + 1'b1;
      // Readback registers only change on a complete reply.
      if (state == S_RECV && rx_full) begin
        if (cmd_q == C_RD_MASK || cmd_q == C_WR_MASK) rd_enable_mask <= shadow[OUTPUT_COUNT-1:0];
        else                                          rd_pin_map     <= shadow[SEL_WIDTH-1:0];
      end
      if (state == S_DONE) armed <= 1'b0;
    end
  end

endmodule

// File: tb/tb_comm_host.sv
// Scoreboard bench for comm_host: uart_tx model checks bytes on the wire, reply bytes are driven by hand.
module tb_comm_host;
  localparam int TMO = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_ready, resp_valid, busy, tx_start, rx_ready = 1'b0;
  logic        tx_done;
  logic [2:0]  req_cmd = '0;
  logic [15:0] wr_enable_mask = '0, rd_enable_mask;
  logic [31:0] wr_pin_map = '0, rd_pin_map;
  logic [1:0]  resp_err;
  logic [7:0]  tx_byte, rx_byte = '0;

  comm_host #(.OUTPUT_COUNT(16), .INPUT_COUNT(4), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .wr_enable_mask(wr_enable_mask), .wr_pin_map(wr_pin_map), .rd_enable_mask(rd_enable_mask),
    .rd_pin_map(rd_pin_map), .resp_valid(resp_valid), .resp_err(resp_err), .busy(busy),
    .tx_byte(tx_byte), .tx_start(tx_start), .tx_done(tx_done), .rx_byte(rx_byte), .rx_ready(rx_ready)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_bad = 0;
  int cyc = 0, tx_seen = 0, tot_tx_exp = 0, resp_cnt = 0, last_resp_cyc = 0, t_last_rx = 0;
  logic [7:0] exp_tx[$];
  logic [1:0] exp_resp[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // uart_tx model: each tx_start must match the next expected byte; busy for 6 cycles.
  initial begin
    tx_done = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (tx_start) begin
        tx_seen++;
        if (exp_tx.size() == 0) chk("tx_unexp", exp_tx.size(), 1);
        else chk("tx_byte", tx_byte, exp_tx.pop_front());
        tx_done = 1'b0;
        repeat (6) @(posedge clk);
        #1 tx_done = 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (resp_valid) begin
        resp_cnt++;
        last_resp_cyc = cyc;
        if (exp_resp.size() == 0) chk("resp_unexp", exp_resp.size(), 1);
        else chk("resp_err", resp_err, exp_resp.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte = b; rx_ready = 1'b1; t_last_rx = cyc;
    tick(); tick();
    rx_ready = 1'b0;
    tick(); tick();
  endtask

  task automatic do_req(input logic [2:0] c, input logic [15:0] m, input logic [31:0] p);
    int n = 0;
    while (!req_ready && n < 200) begin tick(); n++; end
    if (!req_ready) chk("ready_tmo", req_ready, 1);
    req_cmd = c; wr_enable_mask = m; wr_pin_map = p; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic push_req(input logic [2:0] c, input logic [15:0] m, input logic [31:0] p,
                          input logic [1:0] e, output int ntx);
    exp_tx.push_back({5'b0, c});
    ntx = 1;
    if (c == 3'd3) for (int k = 0; k < 2; k++) begin exp_tx.push_back(m[8*k +: 8]); ntx++; end
    if (c == 3'd4) for (int k = 0; k < 4; k++) begin exp_tx.push_back(p[8*k +: 8]); ntx++; end
    exp_resp.push_back(e);
    tot_tx_exp += ntx;
  endtask

  task automatic run(input logic [2:0] c, input logic [15:0] m, input logic [31:0] p,
                     input int nrep, input logic [31:0] rep, input logic [1:0] e, input bit poke);
    int ntx, base_tx, base_resp, n;
    base_tx = tx_seen; base_resp = resp_cnt;
    push_req(c, m, p, e, ntx);
    do_req(c, m, p);
    if (poke) begin
      tick();
      req_cmd = 3'd2; req_valid = 1'b1;
      tick();
      chk("busy_rdy", req_ready, 0);
      req_valid = 1'b0;
    end
    n = 0;
    while (!(tx_seen >= base_tx + ntx && tx_done) && n < 2000) begin tick(); n++; end
    if (n >= 2000) chk("tx_wait", tx_seen, base_tx + ntx);
    for (int k = 0; k < nrep; k++) send_byte(rep[8*k +: 8]);
    n = 0;
    while (resp_cnt == base_resp && n < TMO + 500) begin tick(); n++; end
    if (resp_cnt == base_resp) chk("resp_wait", resp_cnt, base_resp + 1);
    repeat (4) tick();
    chk("resp_once", resp_cnt - base_resp, 1);
  endtask

  initial begin
    int ntx, base_tx, base_resp, n, lat;
    repeat (3) tick();
    chk("rst_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_txs", tx_start, 0);
    chk("rst_txb", tx_byte, 8'hFF);
    chk("rst_rv", resp_valid, 0);
    chk("rst_err", resp_err, 0);
    chk("rst_mask", rd_enable_mask, 0);
    chk("rst_map", rd_pin_map, 0);
    rst = 1'b0;
    tick();

    // Read mask, a trailing extra byte must be ignored.
    run(3'd1, 16'h0, 32'h0, 3, 32'h0077_3CA5, 2'd0, 1'b0);
    chk("rdmask", rd_enable_mask, 16'h3CA5);

    run(3'd4, 16'h0, 32'h1234_5678, 4, 32'h1234_5678, 2'd0, 1'b1);
    chk("wrmap", rd_pin_map, 32'h1234_5678);

`ifdef ECHO_CHECK_EN
    run(3'd3, 16'hBEEF, 32'h0, 2, 32'h0000_BFEF, 2'd3, 1'b0);
`else
    run(3'd3, 16'hBEEF, 32'h0, 2, 32'h0000_BFEF, 2'd0, 1'b0);
`endif
    chk("wrmask_echo", rd_enable_mask, 16'hBFEF);

    run(3'd2, 16'h0, 32'h0, 2, 32'h0000_9988, 2'd1, 1'b0);
    lat = last_resp_cyc - t_last_rx;
    chk("tmo_lat", (lat >= TMO && lat <= TMO + 4) ? 1 : 0, 1);
    chk("tmo_map", rd_pin_map, 32'h1234_5678);

    foreach (req_cmd[i]) begin end
    for (int i = 0; i < 2; i++) begin
      base_resp = resp_cnt;
      exp_resp.push_back(2'd2);
      req_cmd = (i == 0) ? 3'd0 : 3'd7; req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      chk("bad_rv", resp_valid, 1);
      chk("bad_err", resp_err, 2'd2);
      tick();
      chk("bad_ready", req_ready, 1);
      chk("bad_once", resp_cnt - base_resp, 1);
    end

    // Reset while the WR_MAP payload is on the wire.
    base_tx = tx_seen; base_resp = resp_cnt;
    push_req(3'd4, 16'h0, 32'hCAFE_F00D, 2'd0, ntx);
    do_req(3'd4, 16'h0, 32'hCAFE_F00D);
    n = 0;
    while (tx_seen < base_tx + 2 && n < 500) begin tick(); n++; end
    if (tx_seen < base_tx + 2) chk("mid_wait", tx_seen, base_tx + 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_ready", req_ready, 1);
    chk("mid_rv", resp_valid, 0);
    for (int k = 0; k < ntx - 2; k++) void'(exp_tx.pop_back());
    tot_tx_exp -= ntx - 2;
    void'(exp_resp.pop_back());
    repeat (20) tick();
    chk("mid_noresp", resp_cnt, base_resp);

    run(3'd1, 16'h0, 32'h0, 2, 32'h0000_2211, 2'd0, 1'b0);
    chk("post_rst_mask", rd_enable_mask, 16'h2211);

    chk("tx_total", tx_seen, tot_tx_exp);
    chk("tx_left", exp_tx.size(), 0);
    chk("resp_left", exp_resp.size(), 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
